// File: rtl/router_dest_rx.sv
// Destination consumer for one router output port: drains one packet at a time,
// streams payload bytes, and checks the packet's parity and header address.
module router_dest_rx #(
    parameter logic [1:0] PORT_ID     = 2'd0,
    parameter int         RD_DELAY    = 0,
    parameter int         ABORT_LIMIT = 32,
    parameter int         CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       dout,
    input  logic             vld_out,
    output logic             rd_en,
    output logic [7:0]       rx_data,
    output logic             rx_valid,
    output logic [7:0]       rx_hdr,
    output logic             pkt_done,
    output logic             parity_err,
    output logic             addr_err,
    output logic             pkt_drop,
    output logic [CNT_W-1:0] pkt_cnt
);
    typedef enum logic [2:0] {IDLE, DELAY, HDR_RD, HDR_CAP, PLD_RD, CHECK} state_t;

    localparam int             SW         = $clog2(ABORT_LIMIT + 1);
    localparam logic [5:0]     DLY_LAST   = (RD_DELAY > 0) ? 6'(RD_DELAY - 1) : 6'd0;
    localparam logic [SW-1:0]  STALL_LAST = SW'(ABORT_LIMIT - 1);

    state_t        state;
    logic          rd_en_d;
    logic [6:0]    issue_cnt;
    logic [6:0]    cap_cnt;
    logic [7:0]    parity;
    logic [5:0]    dly_cnt;
    logic [SW-1:0] stall_cnt;
    logic          stall_cnt_en;
    logic          capture;
    logic          abort;

    always_comb begin
        rd_en = 1'b0;
        case (state)
            HDR_RD:  rd_en = vld_out;
            PLD_RD:  rd_en = vld_out && (issue_cnt != 7'd0);
            default: rd_en = 1'b0;
        endcase
    end

    // Payload strobe is combinational so it lines up with the byte the FIFO returns.
    assign capture  = rd_en_d && (state == PLD_RD);
    assign rx_valid = capture && (cap_cnt > 7'd1);
    assign rx_data  = rx_valid ? dout : 8'h00;

    // Once every read is issued the FIFO may legitimately run dry, so that is not a stall.
    assign stall_cnt_en = !vld_out &&
                          ((state == HDR_RD) || ((state == PLD_RD) && (issue_cnt != 7'd0)));
    assign abort    = stall_cnt_en && !rd_en_d && (stall_cnt >= STALL_LAST);
    assign pkt_drop = abort || ((state == DELAY) && !vld_out);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            rd_en_d    <= 1'b0;
            issue_cnt  <= 7'd0;
            cap_cnt    <= 7'd0;
            parity     <= 8'h00;
            dly_cnt    <= 6'd0;
            stall_cnt  <= '0;
            rx_hdr     <= 8'h00;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;
            pkt_cnt    <= '0;
        end else begin
            rd_en_d    <= rd_en;
            pkt_done   <= 1'b0;
            parity_err <= 1'b0;
            addr_err   <= 1'b0;

            if (!stall_cnt_en)
                stall_cnt <= '0;
            else
                stall_cnt <= stall_cnt + 1'b1;

            case (state)
                IDLE: begin
                    dly_cnt <= 6'd0;
                    if (vld_out)
                        state <= (RD_DELAY > 0) ? DELAY : HDR_RD;
                end
                DELAY: begin
                    // vld_out dropping here means the router soft-reset its FIFO.
                    if (!vld_out)
                        state <= IDLE;
                    else if (dly_cnt == DLY_LAST)
                        state <= HDR_RD;
                    else
                        dly_cnt <= dly_cnt + 6'd1;
                end
                HDR_RD: begin
                    if (abort)
                        state <= IDLE;
                    else if (rd_en)
                        state <= HDR_CAP;
                end
                HDR_CAP: begin
                    rx_hdr    <= dout;
                    parity    <= dout;
                    issue_cnt <= {1'b0, dout[7:2]} + 7'd1;
                    cap_cnt   <= {1'b0, dout[7:2]} + 7'd1;
                    state     <= PLD_RD;
                end
                PLD_RD: begin
                    if (rd_en)
                        issue_cnt <= issue_cnt - 7'd1;
                    if (abort) begin
                        state <= IDLE;
                    end else if (capture) begin
                        cap_cnt <= cap_cnt - 7'd1;
                        if (cap_cnt > 7'd1) begin
                            parity <= parity ^ dout;
                        end else begin
                            // Last capture is the parity byte; results show during CHECK.
                            state      <= CHECK;
                            pkt_done   <= 1'b1;
                            parity_err <= (parity != dout);
                            addr_err   <= (rx_hdr[1:0] != PORT_ID);
                            if ((parity == dout) && (rx_hdr[1:0] == PORT_ID))
                                pkt_cnt <= pkt_cnt + 1'b1;
                        end
                    end
                end
                CHECK:   state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_router_dest_rx.sv
// Directed bench for router_dest_rx: a byte FIFO model feeds one instance,
// a second instance with a long read delay exercises the soft-reset drop.
module tb_router_dest_rx;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [7:0]  dout = 8'h00;
    logic        vld_out;
    logic        rd_en;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic [7:0]  rx_hdr;
    logic        pkt_done;
    logic        parity_err;
    logic        addr_err;
    logic        pkt_drop;
    logic [15:0] pkt_cnt;

    logic [7:0]  d_dout = 8'h00;
    logic        d_vld = 1'b0;
    logic        d_rd_en;
    logic [7:0]  d_rx_data;
    logic        d_rx_valid;
    logic [7:0]  d_rx_hdr;
    logic        d_pkt_done;
    logic        d_parity_err;
    logic        d_addr_err;
    logic        d_pkt_drop;
    logic [15:0] d_pkt_cnt;

    int ntests = 0;
    int nfail  = 0;

    always #5 clk = ~clk;

    router_dest_rx #(.PORT_ID(2'd1), .RD_DELAY(0), .ABORT_LIMIT(32), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .dout(dout), .vld_out(vld_out), .rd_en(rd_en),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_hdr(rx_hdr), .pkt_done(pkt_done),
        .parity_err(parity_err), .addr_err(addr_err), .pkt_drop(pkt_drop), .pkt_cnt(pkt_cnt)
    );

    router_dest_rx #(.PORT_ID(2'd1), .RD_DELAY(40), .ABORT_LIMIT(32), .CNT_W(16)) dut_d (
        .clk(clk), .rst(rst), .dout(d_dout), .vld_out(d_vld), .rd_en(d_rd_en),
        .rx_data(d_rx_data), .rx_valid(d_rx_valid), .rx_hdr(d_rx_hdr), .pkt_done(d_pkt_done),
        .parity_err(d_parity_err), .addr_err(d_addr_err), .pkt_drop(d_pkt_drop), .pkt_cnt(d_pkt_cnt)
    );

    // Router output FIFO model: data appears the cycle after rd_en.
    logic [7:0] mem [0:255];
    logic [7:0] rptr = 8'd0;
    logic [7:0] wptr = 8'd0;
    assign vld_out = (rptr != wptr);
    always @(posedge clk) begin
        if (rd_en) begin
            dout <= mem[rptr];
            rptr <= rptr + 8'd1;
        end
    end

    int         cyc = 0;
    int         rd_cyc[$];
    int         done_cyc[$];
    int         drop_cyc[$];
    int         dropd_cyc[$];
    logic [1:0] done_err[$];
    logic [7:0] rxq[$];
    int         rdd_n = 0;
    int         overlap_n = 0;
    always @(negedge clk) begin
        if (rd_en) rd_cyc.push_back(cyc);
        if (rx_valid) rxq.push_back(rx_data);
        if (pkt_done) begin
            done_cyc.push_back(cyc);
            done_err.push_back({parity_err, addr_err});
        end
        if (pkt_drop) drop_cyc.push_back(cyc);
        if (d_pkt_drop) dropd_cyc.push_back(cyc);
        if (d_rd_en) rdd_n <= rdd_n + 1;
        if ((pkt_done && pkt_drop) || (d_pkt_done && d_pkt_drop)) overlap_n <= overlap_n + 1;
        cyc <= cyc + 1;
    end

    task automatic send(input logic [63:0] pkt, input int n);
        logic [7:0] b;
        for (int i = n - 1; i >= 0; i--) begin
            b = pkt[8*i +: 8];
            mem[wptr] = b;
            wptr = wptr + 8'd1;
        end
    endtask

    // Bounded wait: which 0 = rd_en log, 1 = pkt_done log, 2 = pkt_drop log.
    task automatic wait_for(input int which, input int target, output bit ok);
        int k = 0;
        ok = 1'b0;
        while (k < 200) begin
            if ((which == 0 && rd_cyc.size() >= target) ||
                (which == 1 && done_cyc.size() >= target) ||
                (which == 2 && drop_cyc.size() >= target)) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk);
            k++;
        end
    endtask

    task automatic test_reset;
        logic [37:0] obs;
        logic [37:0] obs_d;
        repeat (3) @(posedge clk);
        #1;
        obs   = {rd_en, rx_valid, rx_data, rx_hdr, pkt_done, parity_err, addr_err, pkt_drop, pkt_cnt};
        obs_d = {d_rd_en, d_rx_valid, d_rx_data, d_rx_hdr, d_pkt_done, d_parity_err, d_addr_err,
                 d_pkt_drop, d_pkt_cnt};
        ntests++;
        if (obs !== 38'd0) begin
            nfail++;
            $display("FAIL reset_outputs: got %h, expected 0", obs);
        end
        ntests++;
        if (obs_d !== 38'd0) begin
            nfail++;
            $display("FAIL reset_outputs_delay_inst: got %h, expected 0", obs_d);
        end
        rst = 1'b1;
    endtask

    task automatic test_good;
        int r0, d0, x0, t;
        bit ok;
        @(posedge clk);
        #1;
        r0 = rd_cyc.size(); d0 = done_cyc.size(); x0 = rxq.size();
        send(64'h0D_11_22_33_0D, 5);
        wait_for(1, d0 + 1, ok);
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if (!ok || rd_cyc.size() - r0 != 5) begin
            nfail++;
            $display("FAIL good_rd_count: got %0d reads (done=%0d), expected 5", rd_cyc.size() - r0, ok);
        end else begin
            t = rd_cyc[r0];
            ntests++;
            if (rd_cyc[r0+1] != t + 2 || rd_cyc[r0+4] != t + 5) begin
                nfail++;
                $display("FAIL good_rd_pattern: reads at t+%0d..t+%0d, expected t+2..t+5",
                         rd_cyc[r0+1] - t, rd_cyc[r0+4] - t);
            end
            ntests++;
            if (done_cyc[d0] != t + 7) begin
                nfail++;
                $display("FAIL good_latency: pkt_done at t+%0d, expected t+7", done_cyc[d0] - t);
            end
            ntests++;
            if (done_err[d0] !== 2'b00) begin
                nfail++;
                $display("FAIL good_errs: {parity,addr}=%b, expected 00", done_err[d0]);
            end
        end
        ntests++;
        if (rxq.size() - x0 != 3 || rxq[x0] !== 8'h11 || rxq[x0+1] !== 8'h22 || rxq[x0+2] !== 8'h33) begin
            nfail++;
            $display("FAIL good_payload: %0d bytes, expected 11 22 33", rxq.size() - x0);
        end
        ntests++;
        if (pkt_cnt !== 16'd1 || rx_hdr !== 8'h0D) begin
            nfail++;
            $display("FAIL good_cnt_hdr: pkt_cnt=%0d rx_hdr=%h, expected 1 0d", pkt_cnt, rx_hdr);
        end
    endtask

    task automatic test_bad_parity;
        int d0, x0;
        bit ok;
        @(posedge clk);
        #1;
        d0 = done_cyc.size(); x0 = rxq.size();
        send(64'h0D_11_22_33_0C, 5);
        wait_for(1, d0 + 1, ok);
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if (!ok || done_err[d0] !== 2'b10) begin
            nfail++;
            $display("FAIL bad_parity_errs: done=%0d {parity,addr}=%b, expected 10", ok, ok ? done_err[d0] : 2'bxx);
        end
        ntests++;
        if (pkt_cnt !== 16'd1 || rxq.size() - x0 != 3) begin
            nfail++;
            $display("FAIL bad_parity_cnt: pkt_cnt=%0d bytes=%0d, expected 1 and 3", pkt_cnt, rxq.size() - x0);
        end
    endtask

    task automatic test_addr_mismatch;
        int d0, x0;
        bit ok;
        @(posedge clk);
        #1;
        d0 = done_cyc.size(); x0 = rxq.size();
        send(64'h0E_11_22_33_0E, 5);
        wait_for(1, d0 + 1, ok);
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if (!ok || done_err[d0] !== 2'b01) begin
            nfail++;
            $display("FAIL addr_errs: done=%0d {parity,addr}=%b, expected 01", ok, ok ? done_err[d0] : 2'bxx);
        end
        ntests++;
        if (rxq.size() - x0 != 3 || rxq[x0] !== 8'h11 || rxq[x0+2] !== 8'h33) begin
            nfail++;
            $display("FAIL addr_payload: %0d bytes, expected 11 22 33", rxq.size() - x0);
        end
        ntests++;
        if (pkt_cnt !== 16'd1 || rx_hdr !== 8'h0E) begin
            nfail++;
            $display("FAIL addr_cnt_hdr: pkt_cnt=%0d rx_hdr=%h, expected 1 0e", pkt_cnt, rx_hdr);
        end
    endtask

    task automatic test_back_to_back;
        int r0, d0, x0;
        bit ok;
        @(posedge clk);
        #1;
        r0 = rd_cyc.size(); d0 = done_cyc.size(); x0 = rxq.size();
        send(64'h01_01_0D_11_22_33_0D, 7);
        wait_for(1, d0 + 2, ok);
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if (!ok || rd_cyc.size() - r0 != 7) begin
            nfail++;
            $display("FAIL b2b_reads: done=%0d reads=%0d, expected 7", ok, rd_cyc.size() - r0);
        end else begin
            ntests++;
            if (done_cyc[d0] != rd_cyc[r0] + 4 || done_err[d0] !== 2'b00) begin
                nfail++;
                $display("FAIL b2b_len0: done at t+%0d errs=%b, expected t+4 00",
                         done_cyc[d0] - rd_cyc[r0], done_err[d0]);
            end
            ntests++;
            if (rd_cyc[r0+2] != done_cyc[d0] + 2) begin
                nfail++;
                $display("FAIL b2b_gap: second header %0d cycles after done, expected 2",
                         rd_cyc[r0+2] - done_cyc[d0]);
            end
            ntests++;
            if (done_err[d0+1] !== 2'b00) begin
                nfail++;
                $display("FAIL b2b_second_errs: %b, expected 00", done_err[d0+1]);
            end
        end
        ntests++;
        if (rxq.size() - x0 != 3 || pkt_cnt !== 16'd3) begin
            nfail++;
            $display("FAIL b2b_payload_cnt: bytes=%0d pkt_cnt=%0d, expected 3 and 3", rxq.size() - x0, pkt_cnt);
        end
    endtask

    task automatic test_stall_resume;
        int r0, d0, x0, p0;
        bit ok, ok2;
        @(posedge clk);
        #1;
        r0 = rd_cyc.size(); d0 = done_cyc.size(); x0 = rxq.size(); p0 = drop_cyc.size();
        send(64'h0D_11, 2);
        wait_for(0, r0 + 2, ok);
        #1;
        repeat (5) @(posedge clk);
        #1;
        send(64'h22_33_0D, 3);
        wait_for(1, d0 + 1, ok2);
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if (!ok || !ok2 || rd_cyc.size() - r0 != 5) begin
            nfail++;
            $display("FAIL stall_reads: ok=%0d/%0d reads=%0d, expected 5", ok, ok2, rd_cyc.size() - r0);
        end else begin
            ntests++;
            if (rd_cyc[r0+2] != rd_cyc[r0+1] + 6 || done_err[d0] !== 2'b00) begin
                nfail++;
                $display("FAIL stall_resume: gap=%0d errs=%b, expected 6 00",
                         rd_cyc[r0+2] - rd_cyc[r0+1], done_err[d0]);
            end
        end
        ntests++;
        if (rxq.size() - x0 != 3 || rxq[x0+1] !== 8'h22 || drop_cyc.size() != p0 || pkt_cnt !== 16'd4) begin
            nfail++;
            $display("FAIL stall_result: bytes=%0d drops=%0d pkt_cnt=%0d, expected 3 0 4",
                     rxq.size() - x0, drop_cyc.size() - p0, pkt_cnt);
        end
    endtask

    task automatic test_abort;
        int r0, d0, p0;
        bit ok, ok2;
        @(posedge clk);
        #1;
        r0 = rd_cyc.size(); d0 = done_cyc.size(); p0 = drop_cyc.size();
        send(64'h0D_11, 2);
        wait_for(0, r0 + 2, ok);
        wait_for(2, p0 + 1, ok2);
        repeat (5) @(posedge clk);
        #1;
        ntests++;
        if (!ok || !ok2 || drop_cyc[p0] != rd_cyc[r0+1] + 32) begin
            nfail++;
            $display("FAIL abort_timing: ok=%0d/%0d drop %0d cycles after last read, expected 32",
                     ok, ok2, ok2 ? drop_cyc[p0] - rd_cyc[r0+1] : -1);
        end
        ntests++;
        if (drop_cyc.size() != p0 + 1 || done_cyc.size() != d0 || rd_en !== 1'b0) begin
            nfail++;
            $display("FAIL abort_state: drops=%0d dones=%0d rd_en=%b, expected 1 0 0",
                     drop_cyc.size() - p0, done_cyc.size() - d0, rd_en);
        end
        ntests++;
        if (rx_hdr !== 8'h0D || pkt_cnt !== 16'd4) begin
            nfail++;
            $display("FAIL abort_hold: rx_hdr=%h pkt_cnt=%0d, expected 0d 4", rx_hdr, pkt_cnt);
        end
    endtask

    task automatic test_delay_drop;
        int c;
        @(posedge clk);
        #1;
        c = cyc;
        d_vld = 1'b1;
        repeat (30) @(posedge clk);
        #1;
        d_vld = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        ntests++;
        if (dropd_cyc.size() != 1 || dropd_cyc[0] != c + 30) begin
            nfail++;
            $display("FAIL delay_drop: drops=%0d at c+%0d, expected 1 at c+30",
                     dropd_cyc.size(), dropd_cyc.size() > 0 ? dropd_cyc[0] - c : -1);
        end
        ntests++;
        if (rdd_n != 0) begin
            nfail++;
            $display("FAIL delay_no_read: rd_en high %0d cycles, expected 0", rdd_n);
        end
    endtask

    task automatic test_reset_mid;
        int r0, d0, x0;
        bit ok, ok2;
        logic [37:0] obs;
        @(posedge clk);
        #1;
        r0 = rd_cyc.size(); d0 = done_cyc.size();
        send(64'h0D_11_22_33_0D, 5);
        wait_for(0, r0 + 3, ok);
        #1;
        rst = 1'b0;
        #1;
        obs = {rd_en, rx_valid, rx_data, rx_hdr, pkt_done, parity_err, addr_err, pkt_drop, pkt_cnt};
        ntests++;
        if (!ok || obs !== 38'd0) begin
            nfail++;
            $display("FAIL reset_mid_outputs: ok=%0d got %h, expected 0", ok, obs);
        end
        wptr = rptr;
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        d0 = done_cyc.size(); x0 = rxq.size();
        send(64'h0D_11_22_33_0D, 5);
        wait_for(1, d0 + 1, ok2);
        repeat (2) @(posedge clk);
        #1;
        ntests++;
        if (!ok2 || done_err[d0] !== 2'b00 || pkt_cnt !== 16'd1) begin
            nfail++;
            $display("FAIL reset_mid_next: done=%0d pkt_cnt=%0d, expected clean packet and 1", ok2, pkt_cnt);
        end
        ntests++;
        if (rxq.size() - x0 != 3 || rxq[x0] !== 8'h11 || rxq[x0+2] !== 8'h33) begin
            nfail++;
            $display("FAIL reset_mid_payload: %0d bytes, expected 11 22 33", rxq.size() - x0);
        end
    endtask

    initial begin
        test_reset();
        test_good();
        test_bad_parity();
        test_addr_mismatch();
        test_back_to_back();
        test_stall_resume();
        test_abort();
        test_delay_drop();
        test_reset_mid();
        ntests++;
        if (overlap_n != 0) begin
            nfail++;
            $display("FAIL done_drop_overlap: %0d cycles, expected 0", overlap_n);
        end
        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end
endmodule
